// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - AES-128 key schedule generator streaming w0..w43 one word per transfer
module aes_key_expand_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         word_ready,
    output logic         word_valid,
    output logic [31:0]  word_out,
    output logic [5:0]   word_idx,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    // AES S-box, byte k of the table lives at bits [2047-8k -: 8]
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        // ~b == 255-b, so {~b,3'b0} is the bit offset of entry b from the LSB end
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    state_t      r_state;
    logic [31:0] r_win [4];   // w[i-4..i-1] for the next word i once i >= 4; the raw key before that
    logic [7:0]  r_rc;
    logic [31:0] r_word;
    logic [5:0]  r_idx;
    logic        r_valid;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_rot;
    logic [31:0] w_sub;
    logic [31:0] w_sched_word;
    logic [31:0] w_key_word;
    logic [7:0]  w_rc_next;
    logic        w_xfer;
    logic        w_last;
    logic        w_round_word;

    // next schedule word from the sliding window, plus the next raw key word for indices 1..3
    always_comb begin
        w_rot        = {r_win[3][23:0], r_win[3][31:24]};
        w_sub        = {sbox_byte(w_rot[31:24]), sbox_byte(w_rot[23:16]),
                        sbox_byte(w_rot[15:8]),  sbox_byte(w_rot[7:0])};
        w_round_word = (r_idx[1:0] == 2'd3);
        w_sched_word = w_round_word ? (r_win[0] ^ w_sub ^ {r_rc, 24'h0})
                                    : (r_win[0] ^ r_win[3]);
        w_rc_next    = {r_rc[6:0], 1'b0} ^ (r_rc[7] ? 8'h1b : 8'h00);
        w_xfer       = r_valid & word_ready;
        w_last       = (r_idx == 6'd43);
        case (r_idx[1:0])
            2'd0:    w_key_word = r_win[1];
            2'd1:    w_key_word = r_win[2];
            default: w_key_word = r_win[3];
        endcase
    end

    // control FSM and datapath: latch key on start, advance one word per transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_win[0] <= 32'h0;
            r_win[1] <= 32'h0;
            r_win[2] <= 32'h0;
            r_win[3] <= 32'h0;
            r_rc    <= 8'h00;
            r_word  <= 32'h0;
            r_idx   <= 6'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_EXPAND;
                        r_win[0] <= key_in[127:96];
                        r_win[1] <= key_in[95:64];
                        r_win[2] <= key_in[63:32];
                        r_win[3] <= key_in[31:0];
                        r_word   <= key_in[127:96];
                        r_idx    <= 6'd0;
                        r_rc     <= 8'h01;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_EXPAND: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                            if (r_idx < 6'd3) begin
                                // key words pass through untouched; window keeps the whole key
                                r_word <= w_key_word;
                            end else begin
                                r_word   <= w_sched_word;
                                r_win[0] <= r_win[1];
                                r_win[1] <= r_win[2];
                                r_win[2] <= r_win[3];
                                r_win[3] <= w_sched_word;
                                if (w_round_word) begin
                                    r_rc <= w_rc_next;
                                end
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign word_valid = r_valid;
    assign word_out   = r_word;
    assign word_idx   = r_idx;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb/tb_aes_key_expand_seq.sv - randomized self-checking bench for aes_key_expand_seq
module tb_aes_key_expand_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         word_ready;
    logic         word_valid;
    logic [31:0]  word_out;
    logic [5:0]   word_idx;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    aes_key_expand_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .word_ready (word_ready),
        .word_valid (word_valid),
        .word_out   (word_out),
        .word_idx   (word_idx),
        .busy       (busy),
        .done       (done)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  sbox_m [256];
    logic [31:0] ref_w  [44];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15 - n -: 8];
    endfunction

    // S-box from first principles: multiplicative inverse then affine map
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] av  = 8'(a);
            for (int x = 1; x < 256; x++) begin
                if (gf_mul(av, 8'(x)) == 8'h01) inv = 8'(x);
            end
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic build_ref(input logic [127:0] key);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < 4; i++) ref_w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = ref_w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            ref_w[i] = ref_w[i-4] ^ t;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always 1, mode 1: random ready, mode 2: 5-cycle stall at index 4
    task automatic run_exp(input logic [127:0] key, input int mode, input bit inject,
                           input bit skip_start, input bit chain, input logic [127:0] next_key,
                           input bit timing);
        int exp_idx = 0;
        int cyc     = 1;
        int stall   = 0;
        int c43     = 0;
        bit injected = 1'b0;
        bit rdy;
        build_ref(key);
        if (!skip_start) begin
            key_in = key;
            start  = 1'b1;
            step();
            start  = 1'b0;
        end
        while (exp_idx < 44 && cyc < 400) begin
            check("valid", 64'(word_valid), 64'd1);
            check("idx", 64'(word_idx), 64'(exp_idx));
            check("word", 64'(word_out), 64'(ref_w[exp_idx]));
            check("busy", 64'(busy), 64'd1);
            check("done_early", 64'(done), 64'd0);
            if (exp_idx == 43 && c43 == 0) c43 = cyc;
            case (mode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom_range(0, 1));
                default: begin
                    if (exp_idx == 4 && stall < 5) begin
                        rdy = 1'b0;
                        stall++;
                    end else begin
                        rdy = 1'b1;
                    end
                end
            endcase
            word_ready = rdy;
            if (inject && exp_idx == 20 && !injected) begin
                start    = 1'b1;
                key_in   = ~key ^ {$urandom, $urandom, $urandom, $urandom};
                injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            if (rdy) exp_idx++;
            cyc++;
        end
        start = 1'b0;
        check("transfers", 64'(exp_idx), 64'd44);
        check("done_pulse", 64'(done), 64'd1);
        check("valid_after", 64'(word_valid), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        if (timing) begin
            check("cycle_w43", 64'(c43), 64'd44);
            check("cycle_done", 64'(cyc), 64'd45);
        end
        if (chain) begin
            key_in = next_key;
            start  = 1'b1;
            step();
            start  = 1'b0;
        end else begin
            step();
            check("done_single", 64'(done), 64'd0);
        end
    endtask

    task automatic reset_mid(input logic [127:0] key, input logic [127:0] new_key);
        key_in     = key;
        start      = 1'b1;
        step();
        start      = 1'b0;
        word_ready = 1'b1;
        repeat (20) step();
        check("mid_idx", 64'(word_idx), 64'd20);
        rst_n  = 1'b0;
        start  = 1'b1;
        key_in = new_key;
        step();
        rst_n  = 1'b1;
        start  = 1'b0;
        check("rst_valid", 64'(word_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_word", 64'(word_out), 64'd0);
        check("rst_idx", 64'(word_idx), 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("rst_no_done", 64'(done), 64'd0);
            check("rst_idle", 64'(word_valid), 64'd0);
        end
        run_exp(new_key, 1, 1'b0, 1'b0, 1'b0, 128'h0, 1'b0);
    endtask

    initial begin
        logic [127:0] k1;
        logic [127:0] k2;
        rst_n      = 1'b0;
        start      = 1'b0;
        word_ready = 1'b0;
        key_in     = '0;
        build_sbox();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("reset_valid", 64'(word_valid), 64'd0);
        check("reset_word", 64'(word_out), 64'd0);
        check("reset_idx", 64'(word_idx), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        step();
        check("idle_valid", 64'(word_valid), 64'd0);

        run_exp(FIPS_KEY, 0, 1'b0, 1'b0, 1'b0, 128'h0, 1'b1);
        check("fips_w4", 64'(ref_w[4]), 64'h a0fafe17);
        check("fips_w5", 64'(ref_w[5]), 64'h88542cb1);
        check("fips_w7", 64'(ref_w[7]), 64'h2a6c7605);
        check("fips_w40", 64'(ref_w[40]), 64'hd014f9a8);
        check("fips_w43", 64'(ref_w[43]), 64'hb6630ca6);

        run_exp(128'h0, 0, 1'b0, 1'b0, 1'b0, 128'h0, 1'b1);
        check("zero_w4", 64'(ref_w[4]), 64'h62636363);
        check("zero_w40", 64'(ref_w[40]), 64'hb4ef5bcb);

        run_exp(FIPS_KEY, 2, 1'b0, 1'b0, 1'b0, 128'h0, 1'b0);
        run_exp(FIPS_KEY, 1, 1'b0, 1'b0, 1'b0, 128'h0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            k1 = {$urandom, $urandom, $urandom, $urandom};
            run_exp(k1, 1, 1'b0, 1'b0, 1'b0, 128'h0, 1'b0);
        end

        run_exp(FIPS_KEY, 1, 1'b1, 1'b0, 1'b0, 128'h0, 1'b0);

        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        run_exp(k1, 0, 1'b0, 1'b0, 1'b1, k2, 1'b0);
        run_exp(k2, 1, 1'b0, 1'b1, 1'b0, 128'h0, 1'b0);

        k2 = {$urandom, $urandom, $urandom, $urandom};
        reset_mid(FIPS_KEY, k2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
